// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: wire timing, ns-to-cycle conversion,
// decoder state encoding and the GRB color word type.
package ws2812b_pkg;

  // Nominal wire timing shared with the transmitter
  localparam int T0H_NS       = 400;
  localparam int T1H_NS       = 800;
  localparam int T0L_NS       = 850;
  localparam int T1L_NS       = 450;
  localparam int RESET_GAP_NS = 50000;

  // Integer-truncated conversion of a duration to clock cycles
  function automatic int nsToCnt(input int ns, input int periodNs);
    return ns / periodNs;
  endfunction

  typedef enum logic [1:0] {
    WAIT_RESET,
    WAIT_HIGH,
    MEAS_HIGH,
    MEAS_LOW
  } rx_state_e;

  // {G,R,B}, bit 23 is the first bit on the wire
  typedef logic [23:0] color_t;

endpackage

// File: rtl/ws2812b_rx_decoder_if.sv
// Line input and decoded-word outputs of the WS2812B receiver.
interface ws2812b_rx_decoder_if;
  import ws2812b_pkg::*;

  logic        enable;
  logic        DIN;
  color_t      color;
  logic        color_valid;
  logic [15:0] led_index;
  logic        frame_done;
  logic [15:0] frame_led_count;
  logic        error;

  // decoder side
  modport master (
    input  enable, DIN,
    output color, color_valid, led_index, frame_done, frame_led_count, error
  );

  // consumer / line driver side
  modport slave (
    output enable, DIN,
    input  color, color_valid, led_index, frame_done, frame_led_count, error
  );
endinterface

// File: rtl/ws2812b_din_sync.sv
// 2-FF synchronizer for the asynchronous data line plus rise/fall strobes
// taken against a one-cycle delayed copy of the synchronized level.
module ws2812b_din_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dinS,
  output logic rise,
  output logic fall
);
  logic s1;
  logic dinQ;

  // synchronizer stages and the delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      dinS <= 1'b0;
      dinQ <= 1'b0;
    end else begin
      s1   <= din;
      dinS <= s1;
      dinQ <= dinS;
    end
  end

  assign rise = dinS & ~dinQ;
  assign fall = ~dinS & dinQ;
endmodule

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B receiver: classifies high-pulse widths into bits, assembles
// MSB-first 24-bit GRB words, indexes them within a frame, and reports
// frame ends (reset gap) and protocol errors as one-cycle pulses.
module ws2812b_rx_decoder
  import ws2812b_pkg::*;
#(
  parameter int CLK_PERIOD_NS = 10,
  parameter int BIT_THRESH_NS = 600,
  parameter int MIN_HIGH_NS   = 150,
  parameter int MAX_HIGH_NS   = 5000,
  parameter int RESET_NS      = RESET_GAP_NS
) (
  input  logic                  clk,
  input  logic                  reset,
  ws2812b_rx_decoder_if.master  bus
);
  localparam logic [15:0] THRESH_CNT = 16'(nsToCnt(BIT_THRESH_NS, CLK_PERIOD_NS));
  localparam logic [15:0] MIN_CNT    = 16'(nsToCnt(MIN_HIGH_NS, CLK_PERIOD_NS));
  localparam logic [15:0] MAX_CNT    = 16'(nsToCnt(MAX_HIGH_NS, CLK_PERIOD_NS));
  localparam logic [15:0] RESET_CNT  = 16'(nsToCnt(RESET_NS, CLK_PERIOD_NS));

  logic        dinS, rise, fall;
  logic [15:0] durCnt;
  rx_state_e   state, stateNxt;
  logic        shiftEn, frameEnd, protoErr, bitVal;
  color_t      shreg, colorQ;
  logic [4:0]  bitCnt;
  logic [15:0] wordCnt, ledIndexQ, frameCntQ;
  logic        colorValidQ, frameDoneQ, errorQ;

  ws2812b_din_sync uSync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.DIN),
    .dinS  (dinS),
    .rise  (rise),
    .fall  (fall)
  );

  // level-duration counter: restarts on every synchronized edge, saturates
  always_ff @(posedge clk) begin
    if (reset || !bus.enable || rise || fall) durCnt <= '0;
    else if (durCnt != 16'hFFFF)              durCnt <= durCnt + 16'd1;
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_RESET;
    else       state <= stateNxt;
  end

  // next state and single-cycle datapath strobes
  always_comb begin
    stateNxt = state;
    shiftEn  = 1'b0;
    frameEnd = 1'b0;
    protoErr = 1'b0;
    bitVal   = (durCnt >= THRESH_CNT);
    unique case (state)
      WAIT_RESET: if (!dinS && durCnt >= RESET_CNT) stateNxt = WAIT_HIGH;
      WAIT_HIGH:  if (rise) stateNxt = MEAS_HIGH;
      MEAS_HIGH: begin
        if (fall) begin
          if (durCnt < MIN_CNT) begin
            protoErr = 1'b1;
            stateNxt = WAIT_RESET;
          end else begin
            shiftEn  = 1'b1;
            stateNxt = MEAS_LOW;
          end
        end else if (durCnt >= MAX_CNT) begin
          protoErr = 1'b1;
          stateNxt = WAIT_RESET;
        end
      end
      MEAS_LOW: begin
        // gap wins over a coincident rise; the rise still opens the next bit
        if (durCnt >= RESET_CNT) begin
          frameEnd = 1'b1;
          stateNxt = rise ? MEAS_HIGH : WAIT_HIGH;
        end else if (rise) begin
          stateNxt = MEAS_HIGH;
        end
      end
      default: stateNxt = WAIT_RESET;
    endcase
    if (!bus.enable) begin
      stateNxt = WAIT_RESET;
      shiftEn  = 1'b0;
      frameEnd = 1'b0;
      protoErr = 1'b0;
    end
  end

  // bit/word assembly, frame accounting and registered output pulses
  always_ff @(posedge clk) begin
    if (reset || !bus.enable) begin
      shreg       <= '0;
      bitCnt      <= '0;
      wordCnt     <= '0;
      colorQ      <= '0;
      ledIndexQ   <= '0;
      frameCntQ   <= '0;
      colorValidQ <= 1'b0;
      frameDoneQ  <= 1'b0;
      errorQ      <= 1'b0;
    end else begin
      colorValidQ <= 1'b0;
      frameDoneQ  <= 1'b0;
      errorQ      <= 1'b0;
      if (protoErr) begin
        errorQ  <= 1'b1;
        bitCnt  <= '0;
        wordCnt <= '0;
        shreg   <= '0;
      end
      if (shiftEn) begin
        shreg <= {shreg[22:0], bitVal};
        if (bitCnt == 5'd23) begin
          colorQ      <= {shreg[22:0], bitVal};
          colorValidQ <= 1'b1;
          ledIndexQ   <= wordCnt;
          bitCnt      <= '0;
          if (wordCnt != 16'hFFFF) wordCnt <= wordCnt + 16'd1;
        end else begin
          bitCnt <= bitCnt + 5'd1;
        end
      end
      if (frameEnd) begin
        frameDoneQ <= 1'b1;
        frameCntQ  <= wordCnt;
        wordCnt    <= '0;
        bitCnt     <= '0;
        shreg      <= '0;
        // leftover bits mean the last word was cut short
        if (bitCnt != '0) errorQ <= 1'b1;
      end
    end
  end

  assign bus.color           = colorQ;
  assign bus.color_valid     = colorValidQ;
  assign bus.led_index       = ledIndexQ;
  assign bus.frame_done      = frameDoneQ;
  assign bus.frame_led_count = frameCntQ;
  assign bus.error           = errorQ;
endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Bench for the WS2812B receiver: drives wire-level pulse trains, queues
// expected words and frame counts at drive time, and pops/compares them
// when the decoder emits its output pulses.
module tb_ws2812b_rx_decoder;
  import ws2812b_pkg::*;

  localparam int BIT_NS    = T0H_NS + T0L_NS;
  localparam int THRESH_NS = 600;

  typedef struct {
    logic [23:0] color;
    logic [15:0] idx;
  } word_exp_t;

  typedef struct {
    int               nWords;
    logic [2:0][23:0] w;
    int               hi0;
    int               hi1;
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   errSeen = 0;
  int   expErr = 0;
  int   cyc = 0;
  int   lastErrCyc = 0;
  int   startCyc = 0;
  word_exp_t wordQ[$];
  int        frameQ[$];
  word_exp_t monW;
  int        monF;
  frame_t    tbl[3];

  ws2812b_rx_decoder_if bus();

  ws2812b_rx_decoder #(
    .CLK_PERIOD_NS (10),
    .BIT_THRESH_NS (THRESH_NS),
    .MIN_HIGH_NS   (150),
    .MAX_HIGH_NS   (5000),
    .RESET_NS      (50000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (bus.color_valid === 1'b1) begin
      if (wordQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected color_valid: color=%h idx=%0d", bus.color, bus.led_index);
      end else begin
        monW = wordQ.pop_front();
        chk("color", 32'(bus.color), 32'(monW.color));
        chk("led_index", 32'(bus.led_index), 32'(monW.idx));
      end
    end
    if (bus.frame_done === 1'b1) begin
      if (frameQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected frame_done: count=%0d", bus.frame_led_count);
      end else begin
        monF = frameQ.pop_front();
        chk("frame_led_count", 32'(bus.frame_led_count), 32'(monF));
      end
    end
    if (bus.error === 1'b1) begin
      errSeen++;
      lastErrCyc = cyc;
    end
  end

  task automatic sendBit(input logic b, input int hi0, input int hi1);
    int hi;
    hi = b ? hi1 : hi0;
    bus.DIN = 1'b1; #(hi);
    bus.DIN = 1'b0; #(BIT_NS - hi);
  endtask

  // expected word is what the pulse widths decode to, not what was meant
  task automatic sendWord(input logic [23:0] w, input int hi0, input int hi1,
                          input bit want, input int idx);
    word_exp_t e;
    for (int i = 23; i >= 0; i--) e.color[i] = ((w[i] ? hi1 : hi0) >= THRESH_NS);
    e.idx = 16'(idx);
    if (want) wordQ.push_back(e);
    for (int i = 23; i >= 0; i--) sendBit(w[i], hi0, hi1);
  endtask

  task automatic gapLow();
    bus.DIN = 1'b0;
    #(51000);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_color"}, 32'(bus.color), 32'h0);
    chk({tag, "_color_valid"}, 32'(bus.color_valid), 32'h0);
    chk({tag, "_led_index"}, 32'(bus.led_index), 32'h0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'h0);
    chk({tag, "_frame_led_count"}, 32'(bus.frame_led_count), 32'h0);
    chk({tag, "_error"}, 32'(bus.error), 32'h0);
  endtask

  task automatic scenarioEnd(input string tag);
    chk({tag, "_errors"}, 32'(errSeen), 32'(expErr));
    chk({tag, "_words_pending"}, 32'(wordQ.size()), 32'h0);
    chk({tag, "_frames_pending"}, 32'(frameQ.size()), 32'h0);
  endtask

  initial begin
    logic [23:0] w2;
    w2 = 24'h5A5A5A;

    tbl[0].nWords = 1; tbl[0].w = '0; tbl[0].w[0] = 24'hA5F00F;
    tbl[0].hi0 = T0H_NS; tbl[0].hi1 = T1H_NS;
    tbl[1].nWords = 3; tbl[1].w[0] = 24'hFF0000; tbl[1].w[1] = 24'h00FF00; tbl[1].w[2] = 24'h0000FF;
    tbl[1].hi0 = T0H_NS; tbl[1].hi1 = T1H_NS;
    tbl[2].nWords = 1; tbl[2].w = '0; tbl[2].w[0] = 24'hC3A596;
    tbl[2].hi0 = 590; tbl[2].hi1 = 610;

    bus.enable = 1'b1;
    bus.DIN    = 1'b0;
    repeat (3) @(negedge clk);
    chkAllZero("reset");
    reset = 1'b0;
    #2;
    gapLow();

    // well-formed frames, including widths straddling the bit threshold
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < tbl[r].nWords; k++)
        sendWord(tbl[r].w[k], tbl[r].hi0, tbl[r].hi1, 1'b1, k);
      frameQ.push_back(tbl[r].nWords);
      gapLow();
      scenarioEnd($sformatf("frame%0d", r));
    end

    // glitch: error, then a whole word ignored until a reset gap
    bus.DIN = 1'b1; #100;
    bus.DIN = 1'b0; #1000;
    expErr++;
    sendWord(24'h0F0F0F, T0H_NS, T1H_NS, 1'b0, 0);
    gapLow();
    scenarioEnd("glitch");

    // partial word: frame end with zero words and an error
    for (int i = 0; i < 12; i++) sendBit(i[0], T0H_NS, T1H_NS);
    frameQ.push_back(0);
    expErr++;
    gapLow();
    scenarioEnd("partial");

    // stuck high: error about 5 us in, then nothing until a reset gap
    bus.DIN = 1'b1;
    startCyc = cyc;
    #6000;
    bus.DIN = 1'b0;
    #1000;
    expErr++;
    sendWord(24'hABCDEF, T0H_NS, T1H_NS, 1'b0, 0);
    gapLow();
    chk("stuck_latency_ok", 32'((lastErrCyc - startCyc >= 500) && (lastErrCyc - startCyc <= 510)), 32'h1);
    scenarioEnd("stuck");

    // reset in the high pulse of bit 10 of word 2
    sendWord(24'h112233, T0H_NS, T1H_NS, 1'b1, 0);
    for (int i = 23; i > 14; i--) sendBit(w2[i], T0H_NS, T1H_NS);
    bus.DIN = 1'b1; #300;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chkAllZero("midreset");
    reset = 1'b0;
    #200;
    gapLow();
    scenarioEnd("midreset");

    // enable dropped in the same spot; fresh frame starts at index 0
    sendWord(24'h445566, T0H_NS, T1H_NS, 1'b1, 0);
    for (int i = 23; i > 14; i--) sendBit(w2[i], T0H_NS, T1H_NS);
    bus.DIN = 1'b1; #300;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chkAllZero("disable");
    #200;
    bus.DIN = 1'b0;
    #1000;
    bus.enable = 1'b1;
    gapLow();
    sendWord(24'h778899, T0H_NS, T1H_NS, 1'b1, 0);
    frameQ.push_back(1);
    gapLow();
    scenarioEnd("reenable");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
